// File: rtl/memory_dp_clr_if.sv
// ---------------------------------------------------------------------------
// memory_dp_clr_if
// Bus bundle for the memory_dp_clr simple-dual-port RAM.
//   master : requester side. It drives the write and read requests and
//            receives the read data, the valid flag and busy.
//   slave  : the RAM side.
// Signals:
//   busy     RAM is resetting or clearing; requests are ignored
//   wr_en    write request
//   wr_addr  write address
//   wr_be    byte enables; bit i enables wr_data[8i+7:8i]
//   wr_data  write data
//   rd_en    read request
//   rd_addr  read address
//   rd_data  read data; holds its last value when no read completes
//   rd_valid one-cycle pulse marking rd_data valid
// ---------------------------------------------------------------------------
interface memory_dp_clr_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic                      busy;
    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH/8-1:0]   wr_be;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      rd_en;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_valid;

    modport master (
        input  busy, rd_data, rd_valid,
        output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr
    );

    modport slave (
        output busy, rd_data, rd_valid,
        input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr
    );
endinterface

// File: rtl/memory_dp_clr.sv
// ---------------------------------------------------------------------------
// memory_dp_clr
// Simple-dual-port synchronous RAM with one clock, per-byte write enables,
// a read-valid flag and a selectable same-address collision policy. After
// every reset, a clear sequencer writes CLEAR_VAL into each word. While it
// runs, busy is high and all requests are ignored.
//
// Parameters:
//   DATA_WIDTH  word width, a multiple of 8
//   ADDR_WIDTH  address width; the depth is 2**ADDR_WIDTH
//   RD_MODE     0 = a colliding read returns the old word,
//               1 = a colliding read returns the merged (written) word
//   CLEAR_VAL   fill value used by the clear sequencer
// Ports:
//   clk_  clock, rising edge
//   rst_  synchronous reset, active-high
//   bus   memory_dp_clr_if slave modport (requests, read data, busy)
// Optional build macro:
//   MEM_OUT_REG_EN  adds an output register stage. Read latency becomes 2.
//
// FSM states
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_CLEAR | reset or fill in progress; busy=1; requests ignored
//   ST_READY | normal read/write operation
// ---------------------------------------------------------------------------
module memory_dp_clr #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    RD_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
    input  logic             clk_,
    input  logic             rst_,
    memory_dp_clr_if.slave   bus
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [0:0]            state;
    // One bit wider than the address, so the counter cannot wrap.
    logic [ADDR_WIDTH:0]   clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  collide;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_vld_q;

    // ---------------------------------------------------------------
    // Request qualification and collision handling
    // ---------------------------------------------------------------
    always_comb begin
        wr_accept   = (state == ST_READY) && bus.wr_en && !rst_;
        rd_accept   = (state == ST_READY) && bus.rd_en && !rst_;
        collide     = wr_accept && (bus.wr_addr == bus.rd_addr);
        old_word    = mem[bus.rd_addr];
        merged_word = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (bus.wr_be[i]) begin
                merged_word[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
        end
        // A write-through read on a collision sees the same-cycle write.
        if ((RD_MODE == 1) && collide) begin
            rd_word = merged_word;
        end else begin
            rd_word = old_word;
        end
    end

    // ---------------------------------------------------------------
    // Clear / ready sequencer
    // ---------------------------------------------------------------
    always_ff @(posedge clk_) begin
        if (rst_) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + CNT_ONE;
            if (clr_cnt == LAST_ADDR) begin
                state <= ST_READY;
            end
        end
    end

    // ---------------------------------------------------------------
    // Storage array (not reset; the sequencer defines its contents)
    // ---------------------------------------------------------------
    always_ff @(posedge clk_) begin
        if (!rst_ && (state == ST_CLEAR)) begin
            mem[clr_cnt[ADDR_WIDTH-1:0]] <= CLEAR_VAL;
        end else if (wr_accept) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.wr_be[i]) begin
                    mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // First read stage
    // ---------------------------------------------------------------
    always_ff @(posedge clk_) begin
        if (rst_) begin
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_accept;
            if (rd_accept) begin
                rd_q <= rd_word;
            end
        end
    end

`ifdef MEM_OUT_REG_EN
    // The output stage is only re-entered through reset, and reset
    // flushes it. A read that is pending when the FSM drops back to
    // ST_CLEAR never reaches the port.
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_vld_q;

    always_ff @(posedge clk_) begin
        if (rst_) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= rd_vld_q;
            if (rd_vld_q) begin
                out_q <= rd_q;
            end
        end
    end

    assign bus.rd_data  = out_q;
    assign bus.rd_valid = out_vld_q;
`else
    assign bus.rd_data  = rd_q;
    assign bus.rd_valid = rd_vld_q;
`endif

    assign bus.busy = rst_ || (state == ST_CLEAR);

endmodule

// File: tb/tb_memory_dp_clr.sv
// ---------------------------------------------------------------------------
// tb_memory_dp_clr
// Directed bench for memory_dp_clr. It uses two instances:
//   u_dut8  : 8-bit data,  read-old collision policy
//   u_dut32 : 32-bit data, write-through collision policy
// Both instances share clock and reset. The bench is aware of the
// read latency, which changes when MEM_OUT_REG_EN is defined.
// ---------------------------------------------------------------------------
module tb_memory_dp_clr;
`ifdef MEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk_ = 1'b0;
    logic rst_ = 1'b1;
    always #5 clk_ = ~clk_;

    memory_dp_clr_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(5)) b8 ();
    memory_dp_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b32 ();

    memory_dp_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .RD_MODE(0), .CLEAR_VAL(8'h00)) u_dut8 (
        .clk_ (clk_),
        .rst_ (rst_),
        .bus  (b8)
    );

    memory_dp_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RD_MODE(1), .CLEAR_VAL(32'h0)) u_dut32 (
        .clk_ (clk_),
        .rst_ (rst_),
        .bus  (b32)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_);
        #1;
    endtask

    task automatic idle_all();
        b8.wr_en   = 1'b0; b8.rd_en   = 1'b0;
        b8.wr_addr = '0;   b8.rd_addr = '0;
        b8.wr_be   = '0;   b8.wr_data = '0;
        b32.wr_en  = 1'b0; b32.rd_en  = 1'b0;
        b32.wr_addr = '0;  b32.rd_addr = '0;
        b32.wr_be  = '0;   b32.wr_data = '0;
    endtask

    task automatic wr8(input logic [4:0] addr, input logic [7:0] data);
        b8.wr_en = 1'b1; b8.wr_addr = addr; b8.wr_data = data; b8.wr_be = 1'b1;
        tick();
        b8.wr_en = 1'b0;
    endtask

    task automatic wr32(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
        b32.wr_en = 1'b1; b32.wr_addr = addr; b32.wr_data = data; b32.wr_be = be;
        tick();
        b32.wr_en = 1'b0;
    endtask

    task automatic rd8(input logic [4:0] addr, input logic [7:0] exp, input string tag);
        b8.rd_en = 1'b1; b8.rd_addr = addr;
        tick();
        b8.rd_en = 1'b0;
        repeat (LAT - 1) tick();
        chk({tag, "_vld"},  32'(b8.rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(b8.rd_data),  32'(exp));
        tick();
        chk({tag, "_vld_drop"}, 32'(b8.rd_valid), 32'd0);
        chk({tag, "_hold"},     32'(b8.rd_data),  32'(exp));
    endtask

    task automatic rd32(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        b32.rd_en = 1'b1; b32.rd_addr = addr;
        tick();
        b32.rd_en = 1'b0;
        repeat (LAT - 1) tick();
        chk({tag, "_vld"},  32'(b32.rd_valid), 32'd1);
        chk({tag, "_data"}, b32.rd_data,       exp);
        tick();
        chk({tag, "_vld_drop"}, 32'(b32.rd_valid), 32'd0);
    endtask

    task automatic col32(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be,
                         input logic [31:0] exp, input string tag);
        b32.wr_en = 1'b1; b32.wr_addr = addr; b32.wr_data = data; b32.wr_be = be;
        b32.rd_en = 1'b1; b32.rd_addr = addr;
        tick();
        b32.wr_en = 1'b0; b32.rd_en = 1'b0;
        repeat (LAT - 1) tick();
        chk({tag, "_vld"},  32'(b32.rd_valid), 32'd1);
        chk({tag, "_data"}, b32.rd_data,       exp);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int j;
        logic saw_vld;

        idle_all();

        // Test 1: reset state, then clear length and clear contents
        repeat (3) tick();
        chk("rst_busy",  32'(b8.busy),     32'd1);
        chk("rst_vld",   32'(b8.rd_valid), 32'd0);
        chk("rst_data",  32'(b8.rd_data),  32'd0);
        chk("rst_data32", b32.rd_data,     32'd0);
        rst_ = 1'b0;
        n = 0;
        while (b8.busy && n < 100) begin
            tick();
            n++;
        end
        chk("clr_len", 32'(n), 32'd32);
        chk("clr_busy32", 32'(b32.busy), 32'd0);

        for (int i = 0; i < 32 + LAT - 1; i++) begin
            b8.rd_en  = (i < 32);
            b8.rd_addr = 5'(i);
            b32.rd_en = (i < 32);
            b32.rd_addr = 5'(i);
            tick();
            j = i - (LAT - 1);
            if (j >= 0) begin
                chk($sformatf("clr_vld_%0d", j),    32'(b8.rd_valid), 32'd1);
                chk($sformatf("clr_data_%0d", j),   32'(b8.rd_data),  32'd0);
                chk($sformatf("clr_data32_%0d", j), b32.rd_data,      32'd0);
            end
        end
        b8.rd_en = 1'b0; b32.rd_en = 1'b0;
        tick();
        chk("clr_rd_end", 32'(b8.rd_valid), 32'd0);

        // Test 2: write, then read on the following cycle
        wr8(5'd3, 8'hA5);
        rd8(5'd3, 8'hA5, "wr_rd3");

        // Write and read to different addresses in the same cycle
        b8.wr_en = 1'b1; b8.wr_addr = 5'd9; b8.wr_data = 8'h33; b8.wr_be = 1'b1;
        b8.rd_en = 1'b1; b8.rd_addr = 5'd3;
        tick();
        b8.wr_en = 1'b0; b8.rd_en = 1'b0;
        repeat (LAT - 1) tick();
        chk("indep_data", 32'(b8.rd_data), 32'h0000_00A5);
        tick();
        rd8(5'd9, 8'h33, "indep_wr");

        // A write with every byte enable low must leave the word unchanged
        b8.wr_en = 1'b1; b8.wr_addr = 5'd9; b8.wr_data = 8'hFF; b8.wr_be = 1'b0;
        tick();
        b8.wr_en = 1'b0;
        rd8(5'd9, 8'h33, "be_zero");

        // Test 3: partial byte-enable merge
        wr32(5'd4, 32'h1122_3344, 4'b1111);
        wr32(5'd4, 32'hAABB_CCDD, 4'b0101);
        rd32(5'd4, 32'h11BB_33DD, "be_merge");

        // Test 4: collisions, read-old (8-bit) and write-through (32-bit)
        wr8(5'd7, 8'h10);
        b8.wr_en = 1'b1; b8.wr_addr = 5'd7; b8.wr_data = 8'h20; b8.wr_be = 1'b1;
        b8.rd_en = 1'b1; b8.rd_addr = 5'd7;
        tick();
        b8.wr_en = 1'b0; b8.rd_en = 1'b0;
        repeat (LAT - 1) tick();
        chk("col_old_vld",  32'(b8.rd_valid), 32'd1);
        chk("col_old_data", 32'(b8.rd_data),  32'h0000_0010);
        tick();
        rd8(5'd7, 8'h20, "col_old_after");

        wr32(5'd7, 32'h0000_0010, 4'b1111);
        col32(5'd7, 32'h0000_0020, 4'b1111, 32'h0000_0020, "col_wt");
        rd32(5'd7, 32'h0000_0020, "col_wt_after");
        wr32(5'd8, 32'h1122_3344, 4'b1111);
        col32(5'd8, 32'h9988_7766, 4'b0110, 32'h1188_7744, "col_wt_part");
        rd32(5'd8, 32'h1188_7744, "col_wt_part_after");

        // Test 5: reset mid-clear restarts; requests ignored while busy
        rst_ = 1'b1;
        repeat (3) tick();
        rst_ = 1'b0;
        repeat (10) tick();
        rst_ = 1'b1;
        tick();
        rst_ = 1'b0;
        b8.wr_en = 1'b1; b8.wr_addr = 5'd0; b8.wr_data = 8'h55; b8.wr_be = 1'b1;
        b8.rd_en = 1'b1; b8.rd_addr = 5'd0;
        n = 0;
        saw_vld = 1'b0;
        while (b8.busy && n < 100) begin
            tick();
            n++;
            if (b8.rd_valid) saw_vld = 1'b1;
        end
        b8.wr_en = 1'b0; b8.rd_en = 1'b0;
        chk("reclr_len", 32'(n), 32'd32);
        chk("reclr_no_vld", 32'(saw_vld), 32'd0);
        rd8(5'd0, 8'h00, "reclr_addr0");
        rd8(5'd3, 8'h00, "reclr_addr3");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
